// File: rtl/led_ctrl_pkg.sv
// Shared LED controller types: FSM state encoding, duty width/limits and a ramp step helper.
// Purely declarative; no latency and no flow control of its own.
package led_ctrl_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One code toward tgt; cannot wrap because it only moves while cur != tgt.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W-1:0] res;
    res = cur;
    if (cur < tgt)
      res = cur + 1'b1;
    else if (cur > tgt)
      res = cur - 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/led_fade_ctrl_tick_gen.sv
// Free-running divider: tick pulses for one cycle every TICK_DIV cycles, never realigned.
// Output decoded from the counter register; no inputs besides clock and reset, so no backpressure.
module tick_gen #(
  parameter int TICK_DIV = 500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_fade_ctrl.sv
// LED brightness fader: ramps duty one code per tick toward a base level, boosts to full on motion and holds.
// Duty updates on the edge after a tick; set_ready drops only while holding at full brightness.
module led_fade_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 500_000,
  parameter int HOLD_TICKS = 255
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              set_valid,
  input  logic [DUTY_W-1:0] set_level,
  output logic              set_ready,
  input  logic              motion,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              at_max,
  output logic              at_min
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t            state, state_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic [DUTY_W-1:0] target, target_nxt;
  logic [DUTY_W-1:0] base_level, base_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic              mot_flag, mot_flag_nxt;
  logic              motion_prev;
  logic              tick;
  logic              mot_ev;
  logic              xfer;
  logic              hold_last;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (sys_clk),
    .rst  (rst),
    .tick (tick)
  );

  assign mot_ev    = motion && !motion_prev;
  assign xfer      = set_valid && set_ready;
  assign hold_last = (hold_cnt == HOLD_LAST);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RAMP: begin
        if (mot_ev)
          state_nxt = RAMP;
        else if (xfer)
          state_nxt = (set_level == duty) ? IDLE : RAMP;
        else if (state == RAMP && duty == target)
          state_nxt = (mot_flag && target == DUTY_MAX) ? HOLD : IDLE;
      end
      HOLD: begin
        if (!mot_ev && tick && hold_last)
          state_nxt = RAMP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    set_ready = (state != HOLD);
    busy      = (state != IDLE);
  end

  assign at_max = (duty == DUTY_MAX);
  assign at_min = (duty == '0);

  always_comb begin
    duty_nxt     = duty;
    target_nxt   = target;
    base_nxt     = base_level;
    hold_nxt     = hold_cnt;
    mot_flag_nxt = mot_flag;

    if (xfer) begin
      base_nxt   = set_level;
      target_nxt = set_level;
    end
    // Motion outranks a simultaneous request for the target but the request still sets the base.
    if (mot_ev && state != HOLD) begin
      target_nxt   = DUTY_MAX;
      mot_flag_nxt = 1'b1;
    end

    if (state == HOLD) begin
      if (mot_ev)
        hold_nxt = '0;
      else if (tick) begin
        if (hold_last) begin
          target_nxt   = base_level;
          mot_flag_nxt = 1'b0;
        end else
          hold_nxt = hold_cnt + 1'b1;
      end
    end else if (state_nxt == HOLD)
      hold_nxt = '0;

    // Steps toward the post-update target, so a retarget never lets duty jump.
    if (state == RAMP && tick)
      duty_nxt = step_toward(duty, target_nxt);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      duty        <= '0;
      target      <= '0;
      base_level  <= '0;
      hold_cnt    <= '0;
      mot_flag    <= 1'b0;
      motion_prev <= 1'b0;
    end else begin
      duty        <= duty_nxt;
      target      <= target_nxt;
      base_level  <= base_nxt;
      hold_cnt    <= hold_nxt;
      mot_flag    <= mot_flag_nxt;
      motion_prev <= motion;
    end
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Randomised and directed check of led_fade_ctrl against an in-bench behavioural model.
module tb_led_fade_ctrl;

  localparam int TD = 4;
  localparam int HT = 3;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_valid = 1'b0;
  logic [7:0] set_level = 8'd0;
  logic       motion = 1'b0;
  logic       set_ready;
  logic [7:0] duty;
  logic       busy;
  logic       at_max;
  logic       at_min;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model: mode 0 idle, 1 ramping, 2 holding at full; m_hold counts held ticks.
  int m_cnt, m_duty, m_target, m_base, m_mode, m_hold;
  bit m_mflag, m_mprev;

  led_fade_ctrl #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .set_valid (set_valid),
    .set_level (set_level),
    .set_ready (set_ready),
    .motion    (motion),
    .duty      (duty),
    .busy      (busy),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_duty = 0; m_target = 0; m_base = 0;
    m_mode = 0; m_hold = 0; m_mflag = 0; m_mprev = 0;
  endtask

  task automatic model_step();
    bit tk, ev, xf;
    int pm;
    tk = (m_cnt == TD - 1);
    m_cnt = (m_cnt + 1) % TD;
    ev = motion && !m_mprev;
    m_mprev = motion;
    xf = set_valid && (m_mode != 2);
    if (m_mode == 2) begin
      if (ev) m_hold = 0;
      else if (tk) begin
        m_hold++;
        if (m_hold == HT) begin
          m_target = m_base; m_mflag = 0; m_mode = 1;
        end
      end
    end else begin
      pm = m_mode;
      if (xf) begin
        m_base = set_level; m_target = set_level;
        m_mode = (int'(set_level) == m_duty) ? 0 : 1;
      end
      if (ev) begin
        m_target = 255; m_mflag = 1; m_mode = 1;
      end
      if (!xf && !ev && m_mode == 1 && m_duty == m_target) begin
        if (m_mflag && m_target == 255) begin
          m_mode = 2; m_hold = 0;
        end else m_mode = 0;
      end else if (pm == 1 && tk && m_duty != m_target)
        m_duty += (m_target > m_duty) ? 1 : -1;
    end
  endtask

  initial model_reset();

  always @(posedge sys_clk) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge sys_clk) begin
    if (chk_on) begin
      chk("duty", int'(duty), m_duty);
      chk("busy", int'(busy), int'(m_mode != 0));
      chk("set_ready", int'(set_ready), int'(m_mode != 2));
      chk("at_max", int'(at_max), int'(m_duty == 255));
      chk("at_min", int'(at_min), int'(m_duty == 0));
    end
  end

  task automatic cyc();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic pulse_motion();
    motion = 1'b1;
    cyc();
    motion = 1'b0;
  endtask

  task automatic send(input int lvl);
    set_valid = 1'b1;
    set_level = 8'(lvl);
    cyc();
    set_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      cyc(); n++;
    end
    chk(nm, int'(busy), 0);
  endtask

  task automatic wait_duty(input string nm, input int lvl, input int budget);
    int n;
    n = 0;
    while (int'(duty) != lvl && n < budget) begin
      cyc(); n++;
    end
    chk(nm, int'(duty), lvl);
  endtask

  // Counts cycles spent holding; with TD=4 a 3-tick hold lasts 9..12 cycles depending on phase.
  task automatic count_hold(input string nm, output int cycles);
    int n;
    n = 0; cycles = 0;
    while (set_ready !== 1'b0 && n < 1200) begin
      cyc(); n++;
    end
    while (set_ready === 1'b0 && cycles < 100) begin
      cyc(); cycles++;
    end
    chk(nm, int'(cycles >= 3 * TD - 3 && cycles <= 3 * TD), 1);
  endtask

  initial begin
    int hc, n;
    bit saw_max;
    #1;
    chk_on = 1'b1;
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(set_ready), 1);
    chk("rst_at_min", int'(at_min), 1);
    chk("rst_at_max", int'(at_max), 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Plain set from reset
    set_valid = 1'b1; set_level = 8'd10;
    cyc();
    set_valid = 1'b0;
    chk("set10_accept_busy", int'(busy), 1);
    n = 0;
    while (!(duty === 8'd10 && busy === 1'b0) && n < 44) begin
      cyc(); n++;
    end
    chk("set10_done_44", int'(duty === 8'd10 && busy === 1'b0), 1);

    // Motion boost, hold, return to base
    pulse_motion();
    wait_duty("motion_reach_max", 255, 1100);
    count_hold("motion_hold_len", hc);
    wait_idle("motion_return_idle", 1100);
    chk("motion_back_base", int'(duty), 10);

    // Set and motion together: motion wins the target, set becomes the base
    set_valid = 1'b1; set_level = 8'd40; motion = 1'b1;
    cyc();
    set_valid = 1'b0; motion = 1'b0;
    saw_max = 0; n = 0;
    while (busy !== 1'b0 && n < 2500) begin
      if (at_max === 1'b1) saw_max = 1;
      cyc(); n++;
    end
    chk("both_saw_max", int'(saw_max), 1);
    chk("both_settle_40", int'(duty), 40);

    // Retrigger after two held ticks
    pulse_motion();
    n = 0;
    while (m_mode != 2 && n < 1200) begin
      cyc(); n++;
    end
    n = 0;
    while (m_hold != 2 && n < 40) begin
      cyc(); n++;
    end
    pulse_motion();
    hc = 0;
    while (set_ready === 1'b0 && hc < 100) begin
      cyc(); hc++;
    end
    chk("retrigger_hold_len", int'(hc >= 3 * TD - 4 && hc <= 3 * TD - 1), 1);
    wait_idle("retrigger_idle", 1100);
    chk("retrigger_base_40", int'(duty), 40);

    // Retarget mid-ramp
    send(200);
    wait_duty("retarget_reach_120", 120, 400);
    send(50);
    n = 0;
    while (duty === 8'd120 && n < 10) begin
      cyc(); n++;
    end
    chk("retarget_next_119", int'(duty), 119);
    wait_idle("retarget_idle", 400);
    chk("retarget_final_50", int'(duty), 50);

    // Reset mid-ramp
    send(200);
    wait_duty("rst_mid_reach_77", 77, 200);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_duty", int'(duty), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(set_ready), 1);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    send(5);
    n = 0;
    while (!(duty === 8'd5 && busy === 1'b0) && n < 44) begin
      cyc(); n++;
    end
    chk("after_rst_set5", int'(duty === 8'd5 && busy === 1'b0), 1);

    // Motion already high at reset release is an event on the first edge
    rst = 1'b1;
    model_reset();
    motion = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("motion_at_release_busy", int'(busy), 1);
    motion = 1'b0;
    wait_idle("motion_at_release_idle", 2200);
    chk("motion_at_release_base0", int'(duty), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      set_valid = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 7);
      if (r == 0) set_level = 8'(m_duty);
      else if (r == 1) set_level = 8'd255;
      else if (r == 2) set_level = 8'd0;
      else set_level = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 24) == 0) motion = ~motion;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b1;
        model_reset();
      end else rst = 1'b0;
      cyc();
    end
    rst = 1'b0; set_valid = 1'b0; motion = 1'b0;
    cyc();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/led_fade_ctrl.md
LED_FADE_CTRL -- requirements
Module: led_fade_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500_000: sys_clk cycles per ramp step, legal values >= 2.
REQ-002 SHALL have parameter HOLD_TICKS, default 255: ramp ticks held at full brightness after a motion event, legal values >= 1.
REQ-003 SHALL have port sys_clk  in  1  system clock; the only clock in the block, all state on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port set_valid  in  1  a requested base brightness is present.
REQ-006 SHALL have port set_level  in  8  requested base brightness, 0..255.
REQ-007 SHALL have port set_ready  out  1  controller can accept set_level this cycle.
REQ-008 SHALL have port motion  in  1  synchronous motion-detect level; its rising edge is the event.
REQ-009 SHALL have port duty  out  8  registered duty code driven to the PWM din input.
REQ-010 SHALL have port busy  out  1  high while state is not IDLE.
REQ-011 SHALL have ports at_max and at_min  out  1 each: duty==255 and duty==0 respectively.

Function
REQ-012 SHALL run a free-running tick counter, 0..TICK_DIV-1, that wraps to 0; tick is a one-cycle pulse when count==TICK_DIV-1; tick phase is not realigned by requests.
REQ-013 SHALL hold registers duty, target, base_level (8b each), hold_cnt, mot_flag and motion_prev.
REQ-014 SHALL implement states IDLE, RAMP and HOLD.
REQ-015 SHALL drive set_ready = (state != HOLD), combinationally from state only; a transfer occurs on a cycle with set_valid && set_ready.
REQ-016 On transfer, SHALL load base_level<=set_level and target<=set_level, and enter RAMP; it enters IDLE instead if set_level==duty and no motion event occurs that cycle.
REQ-017 A transfer during RAMP SHALL retarget immediately; duty never jumps and the next tick steps toward the new target.
REQ-018 The motion event SHALL be motion && !motion_prev; motion_prev<=motion every cycle.
REQ-019 A motion event in IDLE or RAMP SHALL set target<=255 and mot_flag<=1, and enter RAMP.
REQ-020 A motion event in HOLD SHALL clear hold_cnt to 0 (retrigger) and remain in HOLD.
REQ-021 Motion and transfer in the same cycle: base_level<=set_level; motion wins the target (255).
REQ-022 In RAMP, each tick SHALL move duty by exactly 1 toward target; duty saturates at 0 and 255 and never wraps.
REQ-023 When duty==target in RAMP, the FSM SHALL go to HOLD (hold_cnt<=0) if mot_flag && target==255, else to IDLE; this is evaluated every cycle, not only on tick.
REQ-024 In HOLD, each tick SHALL increment hold_cnt; on a tick with hold_cnt==HOLD_TICKS-1 it SHALL set target<=base_level and mot_flag<=0, and enter RAMP.
REQ-025 If base_level==255 at hold expiry, RAMP SHALL exit to IDLE on the next cycle with duty unchanged.
REQ-026 duty, busy, at_max and at_min SHALL be registered or decoded from registers only; there is no combinational path from inputs to these outputs.

Reset
REQ-027 rst high SHALL immediately force state=IDLE, duty=0, target=0, base_level=0, tick count=0, hold_cnt=0, mot_flag=0 and motion_prev=0, giving set_ready=1, busy=0, at_min=1 and at_max=0.
REQ-028 With motion high at reset release, SHALL detect a motion event on the first clock edge after release.
REQ-029 Reset asserted mid-RAMP or mid-HOLD SHALL abandon the sequence; no pending target survives reset.

Structure
REQ-030 SHALL place the state encoding, DUTY_W=8 and DUTY_MAX=255 in shared package led_ctrl_pkg.
REQ-031 SHALL implement the tick counter as sub-module tick_gen (parameter TICK_DIV, outputs tick), reusable by other LED blocks.

Verification (TICK_DIV=4, HOLD_TICKS=3)
REQ-032 Set 10 from reset -> transfer accepted in 1 cycle; duty steps 0->10, one step per tick, done within 44 cycles; then busy=0 and state is IDLE.
REQ-033 base_level=10, then a motion pulse -> duty ramps to 255; holds exactly 3 ticks with set_ready=0; ramps back to 10; busy=0.
REQ-034 set_valid with level 40 and a motion edge in the same cycle -> duty ramps to 255, holds, then settles at 40.
REQ-035 Set 200, then set 50 while duty==120 rising -> the next tick gives duty 119, descending to 50 with no jump.
REQ-036 A second motion edge after 2 hold ticks -> 3 further ticks are held before the descent starts.
REQ-037 rst asserted mid-ramp at duty 77 -> duty=0 and busy=0 before the next clock edge; after release, set 5 works normally.
